// File: rtl/rab_ar_issue.sv
// AR issue stage: pairs translator results with queued request metadata and
// either issues the translated AR or answers a faulted request with SLVERR beats.
module rab_ar_issue #(
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_,

    input  logic [ID_W+12:0]  meta_tdata,
    input  logic              meta_tvalid,
    output logic              meta_tready,

    input  logic [32:0]       axis_ord_tdata,
    input  logic              axis_ord_tvalid,
    output logic              axis_ord_tready,

    output logic [31:0]       m_axi_araddr,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,

    output logic [ID_W-1:0]   flt_rid,
    output logic [63:0]       flt_rdata,
    output logic [1:0]        flt_rresp,
    output logic              flt_rlast,
    output logic              flt_rvalid,
    input  logic              flt_rready,

    output logic [15:0]       fault_cnt
);

    // state   | meaning
    // S_IDLE  | waiting for a translator result (only when metadata is queued)
    // S_ISSUE | translated AR presented to memory until arready
    // S_FAULT | emitting arlen+1 SLVERR beats for a faulted request
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FAULT} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic [ID_W+12:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [2:0]        arsize_q, arsize_d;
    logic [1:0]        arburst_q, arburst_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [7:0]        rlen_q, rlen_d;
    logic [7:0]        beat_q, beat_d;
    logic [15:0]       fcnt_q, fcnt_d;

    logic              full, empty, push, ord_hs;
    logic [ID_W+12:0]  head;

    assign full            = (cnt_q == FULL_CNT);
    assign empty           = (cnt_q == '0);
    assign meta_tready     = ~full;
    assign axis_ord_tready = (state_q == S_IDLE) && !empty;
    // A pop in the same cycle does not free space for a push while full.
    assign push            = meta_tvalid && !full;
    assign ord_hs          = axis_ord_tvalid && axis_ord_tready;
    assign head            = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        araddr_d  = araddr_q;
        arid_d    = arid_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rid_d     = rid_q;
        rlen_d    = rlen_q;
        beat_d    = beat_q;
        fcnt_d    = fcnt_q;

        if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
        if (ord_hs) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, ord_hs})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (ord_hs) begin
                    if (axis_ord_tdata[32]) begin
                        araddr_d  = axis_ord_tdata[31:0];
                        arid_d    = head[ID_W+12:13];
                        arlen_d   = head[12:5];
                        arsize_d  = head[4:2];
                        arburst_d = head[1:0];
                        state_d   = S_ISSUE;
                    end else begin
                        rid_d   = head[ID_W+12:13];
                        rlen_d  = head[12:5];
                        beat_d  = '0;
                        if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
                        state_d = S_FAULT;
                    end
                end
            end
            S_ISSUE: begin
                if (m_axi_arready) state_d = S_IDLE;
            end
            S_FAULT: begin
                if (flt_rready) begin
                    if (beat_q == rlen_q) state_d = S_IDLE;
                    else                  beat_d  = beat_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            araddr_q  <= '0;
            arid_q    <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rid_q     <= '0;
            rlen_q    <= '0;
            beat_q    <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            araddr_q  <= araddr_d;
            arid_q    <= arid_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rid_q     <= rid_d;
            rlen_q    <= rlen_d;
            beat_q    <= beat_d;
            fcnt_q    <= fcnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= meta_tdata;
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = arburst_q;
    assign m_axi_arvalid = (state_q == S_ISSUE);

    assign flt_rvalid    = (state_q == S_FAULT);
    assign flt_rid       = rid_q;
    assign flt_rdata     = '0;
    assign flt_rresp     = flt_rvalid ? 2'b10 : 2'b00;
    assign flt_rlast     = flt_rvalid && (beat_q == rlen_q);
    assign fault_cnt     = fcnt_q;

endmodule

// File: tb/tb_rab_ar_issue.sv
module tb_rab_ar_issue;
    localparam int ID_W  = 4;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset_;
    logic [ID_W+12:0]  meta_tdata;
    logic              meta_tvalid, meta_tready;
    logic [32:0]       axis_ord_tdata;
    logic              axis_ord_tvalid, axis_ord_tready;
    logic [31:0]       m_axi_araddr;
    logic [ID_W-1:0]   m_axi_arid;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid, m_axi_arready;
    logic [ID_W-1:0]   flt_rid;
    logic [63:0]       flt_rdata;
    logic [1:0]        flt_rresp;
    logic              flt_rlast, flt_rvalid, flt_rready;
    logic [15:0]       fault_cnt;

    rab_ar_issue #(.ID_W(ID_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_(reset_),
        .meta_tdata(meta_tdata), .meta_tvalid(meta_tvalid), .meta_tready(meta_tready),
        .axis_ord_tdata(axis_ord_tdata), .axis_ord_tvalid(axis_ord_tvalid),
        .axis_ord_tready(axis_ord_tready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .flt_rid(flt_rid), .flt_rdata(flt_rdata), .flt_rresp(flt_rresp),
        .flt_rlast(flt_rlast), .flt_rvalid(flt_rvalid), .flt_rready(flt_rready),
        .fault_cnt(fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } meta_t;
    typedef struct {
        logic [31:0]     addr;
        logic [ID_W-1:0] id;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
    } ar_t;
    typedef struct {
        logic [ID_W-1:0] id;
        logic            last;
    } beat_t;

    meta_t       mq[$];
    ar_t         arq[$];
    beat_t       bq[$];
    int unsigned fcnt_m;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    int beat_hs_n = 0;
    int last_n = 0;
    int ar_hs_cyc[$];

    function automatic void chk(input string tag, input bit ok, input logic [63:0] obs,
                                input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [ID_W+12:0] mk(input int id, input int len, input int size,
                                            input int burst);
        return {ID_W'(id), 8'(len), 3'(size), 2'(burst)};
    endfunction

    task automatic cyc();
        logic              exp_mrdy, exp_ordy, exp_arv, exp_rv, hs_m, hs_o, hs_ar, hs_r, rst, dut_rlast;
        logic [ID_W+12:0]  md;
        logic [32:0]       od;
        meta_t             m;
        exp_mrdy = (mq.size() < DEPTH);
        exp_ordy = (arq.size() == 0) && (bq.size() == 0) && (mq.size() > 0);
        exp_arv  = (arq.size() > 0);
        exp_rv   = (bq.size() > 0);
        chk("meta_tready", meta_tready === exp_mrdy, meta_tready, exp_mrdy);
        chk("ord_tready", axis_ord_tready === exp_ordy, axis_ord_tready, exp_ordy);
        chk("arvalid", m_axi_arvalid === exp_arv, m_axi_arvalid, exp_arv);
        chk("rvalid", flt_rvalid === exp_rv, flt_rvalid, exp_rv);
        chk("valid_excl", (m_axi_arvalid && flt_rvalid) === 1'b0, m_axi_arvalid && flt_rvalid, 0);
        chk("fault_cnt", 32'(fault_cnt) === 32'(fcnt_m), fault_cnt, fcnt_m);
        if (arq.size() > 0) begin
            chk("araddr", m_axi_araddr === arq[0].addr, m_axi_araddr, arq[0].addr);
            chk("arid", m_axi_arid === arq[0].id, m_axi_arid, arq[0].id);
            chk("arlen", m_axi_arlen === arq[0].len, m_axi_arlen, arq[0].len);
            chk("arsize", m_axi_arsize === arq[0].size, m_axi_arsize, arq[0].size);
            chk("arburst", m_axi_arburst === arq[0].burst, m_axi_arburst, arq[0].burst);
        end
        if (bq.size() > 0) begin
            chk("rid", flt_rid === bq[0].id, flt_rid, bq[0].id);
            chk("rdata", flt_rdata === 64'd0, flt_rdata, 0);
            chk("rresp", flt_rresp === 2'b10, flt_rresp, 2'b10);
            chk("rlast", flt_rlast === bq[0].last, flt_rlast, bq[0].last);
        end
        hs_m      = meta_tvalid && exp_mrdy;
        hs_o      = axis_ord_tvalid && exp_ordy;
        hs_ar     = m_axi_arready && (arq.size() > 0);
        hs_r      = flt_rready && flt_rvalid;
        dut_rlast = flt_rlast;
        rst       = reset_;
        md        = meta_tdata;
        od        = axis_ord_tdata;
        @(posedge clk);
        cyc_n++;
        if (!rst) begin
            mq.delete();
            arq.delete();
            bq.delete();
            fcnt_m = 0;
        end else begin
            if (hs_ar) begin
                ar_hs_cyc.push_back(cyc_n);
                void'(arq.pop_front());
            end
            if (hs_r) begin
                beat_hs_n++;
                if (dut_rlast) last_n++;
                if (bq.size() > 0) void'(bq.pop_front());
            end
            if (hs_o) begin
                m = mq.pop_front();
                if (od[32]) begin
                    arq.push_back('{addr: od[31:0], id: m.id, len: m.len, size: m.size,
                                    burst: m.burst});
                end else begin
                    for (int i = 0; i <= int'(m.len); i++)
                        bq.push_back('{id: m.id, last: (i == int'(m.len))});
                    if (fcnt_m < 32'hFFFF) fcnt_m++;
                end
            end
            if (hs_m) begin
                m.id    = md[ID_W+12:13];
                m.len   = md[12:5];
                m.size  = md[4:2];
                m.burst = md[1:0];
                mq.push_back(m);
            end
        end
        @(negedge clk);
    endtask

    task automatic push_meta(input logic [ID_W+12:0] d);
        meta_tdata  = d;
        meta_tvalid = 1'b1;
        cyc();
        meta_tvalid = 1'b0;
    endtask

    initial begin
        reset_          = 1'b0;
        meta_tdata      = '0;
        meta_tvalid     = 1'b0;
        axis_ord_tdata  = '0;
        axis_ord_tvalid = 1'b0;
        m_axi_arready   = 1'b0;
        flt_rready      = 1'b0;
        fcnt_m          = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;

        chk("rst_arvalid", m_axi_arvalid === 1'b0, m_axi_arvalid, 0);
        chk("rst_rvalid", flt_rvalid === 1'b0, flt_rvalid, 0);
        chk("rst_ordy", axis_ord_tready === 1'b0, axis_ord_tready, 0);
        chk("rst_mrdy", meta_tready === 1'b1, meta_tready, 1);
        chk("rst_fcnt", fault_cnt === 16'd0, fault_cnt, 0);
        chk("rst_araddr", m_axi_araddr === 32'd0, m_axi_araddr, 0);
        chk("rst_arid", m_axi_arid === 4'd0, m_axi_arid, 0);
        chk("rst_rid", flt_rid === 4'd0, flt_rid, 0);
        chk("rst_rresp", flt_rresp === 2'b00, flt_rresp, 0);
        chk("rst_rlast", flt_rlast === 1'b0, flt_rlast, 0);

        push_meta(mk(3, 0, 3, 1));
        axis_ord_tdata  = {1'b1, 32'h0000_2040};
        axis_ord_tvalid = 1'b1;
        chk("ok_ordy", axis_ord_tready === 1'b1, axis_ord_tready, 1);
        cyc();
        axis_ord_tvalid = 1'b0;
        chk("ok_araddr", m_axi_araddr === 32'h2040, m_axi_araddr, 32'h2040);
        chk("ok_arid", m_axi_arid === 4'd3, m_axi_arid, 3);
        chk("ok_arvalid", m_axi_arvalid === 1'b1, m_axi_arvalid, 1);
        m_axi_arready = 1'b1;
        cyc();
        m_axi_arready = 1'b0;
        chk("ok_done_arvalid", m_axi_arvalid === 1'b0, m_axi_arvalid, 0);
        chk("ok_fcnt", fault_cnt === 16'd0, fault_cnt, 0);

        push_meta(mk(5, 3, 2, 1));
        axis_ord_tdata  = {1'b0, 32'hDEAD_BEEF};
        axis_ord_tvalid = 1'b1;
        cyc();
        axis_ord_tvalid = 1'b0;
        beat_hs_n = 0;
        last_n    = 0;
        for (int i = 0; i < 16 && bq.size() > 0; i++) begin
            flt_rready = (i % 2 == 0);
            cyc();
        end
        flt_rready = 1'b0;
        chk("flt_beats", beat_hs_n === 4, beat_hs_n, 4);
        chk("flt_lasts", last_n === 1, last_n, 1);
        chk("flt_fcnt", fault_cnt === 16'd1, fault_cnt, 1);
        chk("flt_rvalid_end", flt_rvalid === 1'b0, flt_rvalid, 0);

        axis_ord_tdata  = {1'b1, 32'h0000_3000};
        axis_ord_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("empty_ordy", axis_ord_tready === 1'b0, axis_ord_tready, 0);
            cyc();
        end
        push_meta(mk(7, 0, 1, 0));
        chk("late_ordy", axis_ord_tready === 1'b1, axis_ord_tready, 1);
        cyc();
        axis_ord_tvalid = 1'b0;
        m_axi_arready   = 1'b1;
        cyc();
        m_axi_arready   = 1'b0;

        for (int k = 0; k < 5; k++) begin
            meta_tdata  = mk(k + 1, 0, k, 1);
            meta_tvalid = 1'b1;
            chk("fill_mrdy", meta_tready === (k < 4), meta_tready, k < 4);
            cyc();
        end
        meta_tdata      = mk(14, 0, 0, 0);
        meta_tvalid     = 1'b1;
        axis_ord_tdata  = {1'b1, 32'h0000_4000};
        axis_ord_tvalid = 1'b1;
        chk("full_mrdy", meta_tready === 1'b0, meta_tready, 0);
        cyc();
        meta_tvalid     = 1'b0;
        axis_ord_tvalid = 1'b0;
        chk("occ3_mrdy", meta_tready === 1'b1, meta_tready, 1);
        m_axi_arready = 1'b1;
        cyc();
        m_axi_arready = 1'b0;
        push_meta(mk(12, 0, 0, 2));
        chk("occ4_mrdy", meta_tready === 1'b0, meta_tready, 0);
        axis_ord_tvalid = 1'b1;
        m_axi_arready   = 1'b1;
        for (int i = 0; i < 30 && (mq.size() > 0 || arq.size() > 0); i++) begin
            axis_ord_tdata = {1'b1, 32'h0000_5000 + 32'(i * 64)};
            cyc();
        end
        axis_ord_tvalid = 1'b0;
        m_axi_arready   = 1'b0;
        chk("drain1_mrdy", meta_tready === 1'b1, meta_tready, 1);
        chk("drain1_ordy", axis_ord_tready === 1'b0, axis_ord_tready, 0);

        push_meta(mk(2, 255, 0, 1));
        axis_ord_tdata  = {1'b0, 32'h0};
        axis_ord_tvalid = 1'b1;
        cyc();
        axis_ord_tvalid = 1'b0;
        beat_hs_n  = 0;
        last_n     = 0;
        flt_rready = 1'b1;
        for (int i = 0; i < 300 && bq.size() > 0; i++) cyc();
        flt_rready = 1'b0;
        chk("len255_beats", beat_hs_n === 256, beat_hs_n, 256);
        chk("len255_lasts", last_n === 1, last_n, 1);
        chk("len255_fcnt", fault_cnt === 16'd2, fault_cnt, 2);

        push_meta(mk(9, 1, 2, 1));
        push_meta(mk(10, 2, 2, 1));
        push_meta(mk(11, 3, 2, 1));
        ar_hs_cyc.delete();
        axis_ord_tvalid = 1'b1;
        m_axi_arready   = 1'b1;
        for (int i = 0; i < 20 && (mq.size() > 0 || arq.size() > 0); i++) begin
            axis_ord_tdata = {1'b1, 32'h0001_0000 + 32'(cyc_n * 16)};
            cyc();
        end
        axis_ord_tvalid = 1'b0;
        m_axi_arready   = 1'b0;
        chk("b2b_count", ar_hs_cyc.size() === 3, ar_hs_cyc.size(), 3);
        if (ar_hs_cyc.size() == 3) begin
            chk("b2b_gap1", (ar_hs_cyc[1] - ar_hs_cyc[0]) === 2, ar_hs_cyc[1] - ar_hs_cyc[0], 2);
            chk("b2b_gap2", (ar_hs_cyc[2] - ar_hs_cyc[1]) === 2, ar_hs_cyc[2] - ar_hs_cyc[1], 2);
        end

        push_meta(mk(6, 7, 0, 1));
        push_meta(mk(1, 0, 0, 1));
        axis_ord_tdata  = {1'b0, 32'h0};
        axis_ord_tvalid = 1'b1;
        cyc();
        axis_ord_tvalid = 1'b0;
        flt_rready = 1'b1;
        cyc();
        cyc();
        chk("mid_rvalid", flt_rvalid === 1'b1, flt_rvalid, 1);
        reset_ = 1'b0;
        cyc();
        reset_ = 1'b1;
        chk("rst2_rvalid", flt_rvalid === 1'b0, flt_rvalid, 0);
        chk("rst2_fcnt", fault_cnt === 16'd0, fault_cnt, 0);
        chk("rst2_ordy", axis_ord_tready === 1'b0, axis_ord_tready, 0);
        chk("rst2_mrdy", meta_tready === 1'b1, meta_tready, 1);
        beat_hs_n = 0;
        repeat (5) cyc();
        chk("rst2_nobeats", beat_hs_n === 0, beat_hs_n, 0);
        flt_rready = 1'b0;

        for (int i = 0; i < 600; i++) begin
            meta_tdata       = (ID_W+13)'($urandom);
            meta_tdata[12:5] = 8'($urandom_range(0, 3));
            meta_tvalid      = ($urandom_range(0, 1) == 1);
            axis_ord_tdata   = {($urandom_range(0, 3) != 0), 32'($urandom)};
            axis_ord_tvalid  = ($urandom_range(0, 2) != 0);
            m_axi_arready    = ($urandom_range(0, 1) == 1);
            flt_rready       = ($urandom_range(0, 2) != 0);
            cyc();
        end
        meta_tvalid     = 1'b0;
        axis_ord_tvalid = 1'b1;
        m_axi_arready   = 1'b1;
        flt_rready      = 1'b1;
        for (int i = 0; i < 400 && (mq.size() > 0 || arq.size() > 0 || bq.size() > 0); i++) begin
            axis_ord_tdata = {($urandom_range(0, 1) == 1), 32'($urandom)};
            cyc();
        end
        axis_ord_tvalid = 1'b0;
        cyc();
        chk("end_mrdy", meta_tready === 1'b1, meta_tready, 1);
        chk("end_ordy", axis_ord_tready === 1'b0, axis_ord_tready, 0);
        chk("end_arvalid", m_axi_arvalid === 1'b0, m_axi_arvalid, 0);
        chk("end_rvalid", flt_rvalid === 1'b0, flt_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
